// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory responder.
// States, opcodes and address-phase length.
package spi_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RD_DATA,
        WR_DATA,
        IGNORE
    } state_t;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;

    localparam int ADDR_PHASE_BITS = 24;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes the SPI pins into clk and produces one-clk
// edge pulses for sclk and cs_n.
module spi_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic cs_active,
    output logic mosi_s
);

    logic [STAGES-1:0] sclk_q;
    logic [STAGES-1:0] cs_q;
    logic [STAGES-1:0] mosi_q;
    logic              sclk_p;
    logic              cs_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
            sclk_p <= 1'b0;
            cs_p   <= 1'b1;
        end else begin
            sclk_q <= {sclk_q[STAGES-2:0], sclk};
            cs_q   <= {cs_q[STAGES-2:0], cs_n};
            mosi_q <= {mosi_q[STAGES-2:0], mosi};
            sclk_p <= sclk_q[STAGES-1];
            cs_p   <= cs_q[STAGES-1];
        end
    end

    // mosi has the same depth as sclk, so it is stable at the rise pulse
    assign mosi_s    = mosi_q[STAGES-1];
    assign cs_active = ~cs_q[STAGES-1];
    assign sclk_rise =  sclk_q[STAGES-1] & ~sclk_p;
    assign sclk_fall = ~sclk_q[STAGES-1] &  sclk_p;
    assign cs_fall   = ~cs_q[STAGES-1] &  cs_p;
    assign cs_rise   =  cs_q[STAGES-1] & ~cs_p;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 target fronting a byte-wide synchronous memory.
// Supports READ 0x03 / WRITE 0x02 with 24-bit address bursts.
module spi_mem_responder
    import spi_mem_pkg::*;
#(
    parameter int ADDR_BITS   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk,
    input  logic                 cs_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_re,
    input  logic [7:0]           mem_rdata,
    output logic                 mem_we,
    output logic [7:0]           mem_wdata,
    output logic                 busy,
    output logic                 bad_cmd
);

    logic sclk_rise, sclk_fall;
    logic cs_fall, cs_rise;
    logic cs_active, mosi_s;
    logic rise, fall;

    spi_pin_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .cs_active (cs_active),
        .mosi_s    (mosi_s)
    );

    assign rise = sclk_rise & cs_active;
    assign fall = sclk_fall & cs_active;

    state_t               state, state_d;
    logic [4:0]           bit_cnt, bit_cnt_d;
    logic [23:0]          rx, rx_d, rx_nx;
    logic [7:0]           tx, tx_d;
    logic                 is_rd, is_rd_d;
    logic                 ld;
    logic                 inc, inc_d;
    logic                 miso_d, oe_d;
    logic                 re_d, we_d, bad_d;
    logic [ADDR_BITS-1:0] addr_d;
    logic [7:0]           wdata_d;

    assign rx_nx = {rx[22:0], mosi_s};
    assign busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx        <= '0;
            tx        <= '0;
            is_rd     <= 1'b0;
            ld        <= 1'b0;
            inc       <= 1'b0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            bad_cmd   <= 1'b0;
        end else begin
            state     <= state_d;
            bit_cnt   <= bit_cnt_d;
            rx        <= rx_d;
            tx        <= tx_d;
            is_rd     <= is_rd_d;
            ld        <= mem_re;
            inc       <= inc_d;
            miso      <= miso_d;
            miso_oe   <= oe_d;
            mem_addr  <= addr_d;
            mem_re    <= re_d;
            mem_we    <= we_d;
            mem_wdata <= wdata_d;
            bad_cmd   <= bad_d;
        end
    end

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        rx_d      = rx;
        tx_d      = tx;
        is_rd_d   = is_rd;
        inc_d     = 1'b0;
        miso_d    = miso;
        oe_d      = miso_oe;
        addr_d    = mem_addr;
        re_d      = 1'b0;
        we_d      = 1'b0;
        wdata_d   = mem_wdata;
        bad_d     = bad_cmd;

        // read data arrives one clk after the strobe
        if (ld) tx_d = mem_rdata;
        if (inc) addr_d = mem_addr + ADDR_BITS'(1);

        if (cs_rise) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
            oe_d      = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state_d   = CMD;
                        bit_cnt_d = '0;
                        oe_d      = 1'b1;
                    end
                end
                CMD: begin
                    if (rise) begin
                        rx_d      = rx_nx;
                        bit_cnt_d = bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt_d = '0;
                            unique case (1'b1)
                                (rx_nx[7:0] == OP_READ): begin
                                    state_d = ADDR;
                                    is_rd_d = 1'b1;
                                end
                                (rx_nx[7:0] == OP_WRITE): begin
                                    state_d = ADDR;
                                    is_rd_d = 1'b0;
                                end
                                default: begin
                                    state_d = IGNORE;
                                    bad_d   = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                ADDR: begin
                    if (rise) begin
                        rx_d      = rx_nx;
                        bit_cnt_d = bit_cnt + 5'd1;
                        if (bit_cnt == 5'(ADDR_PHASE_BITS - 1)) begin
                            bit_cnt_d = '0;
                            addr_d    = rx_nx[ADDR_BITS-1:0];
                            if (is_rd) begin
                                re_d    = 1'b1;
                                state_d = RD_DATA;
                            end else begin
                                state_d = WR_DATA;
                            end
                        end
                    end
                end
                RD_DATA: begin
                    if (fall) begin
                        miso_d = tx[7];
                        tx_d   = {tx[6:0], 1'b0};
                    end else if (rise) begin
                        bit_cnt_d = bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt_d = '0;
                            addr_d    = mem_addr + ADDR_BITS'(1);
                            re_d      = 1'b1;
                        end
                    end
                end
                WR_DATA: begin
                    if (rise) begin
                        rx_d      = rx_nx;
                        bit_cnt_d = bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt_d = '0;
                            wdata_d   = rx_nx[7:0];
                            we_d      = 1'b1;
                            inc_d     = 1'b1;
                        end
                    end
                end
                IGNORE: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed bench for spi_mem_responder with a byte memory model
// and a strobe monitor.
module tb_spi_mem_responder;

    logic        clk;
    logic        rst;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        bad_cmd;

    int checks = 0;
    int errors = 0;

    spi_mem_responder #(
        .ADDR_BITS   (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .bad_cmd   (bad_cmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    logic [15:0] we_addr [0:63];
    logic [7:0]  we_data [0:63];
    logic [15:0] re_addr [0:63];
    int          we_cnt = 0;
    int          re_cnt = 0;
    int          viol   = 0;
    logic        re_q   = 1'b0;
    logic        we_q   = 1'b0;

    always @(posedge clk) begin
        if (mem_re && mem_we) viol++;
        if (mem_re && re_q) viol++;
        if (mem_we && we_q) viol++;
        re_q = mem_re;
        we_q = mem_we;
        if (mem_re) begin
            mem_rdata <= mem[mem_addr];
            if (re_cnt < 64) re_addr[re_cnt] = mem_addr;
            re_cnt++;
        end
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            if (we_cnt < 64) begin
                we_addr[we_cnt] = mem_addr;
                we_data[we_cnt] = mem_wdata;
            end
            we_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n,
                            output logic [7:0] r);
        r = '0;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            tick(8);
            r[i] = miso;
            sclk = 1'b1;
            tick(8);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        spi_bits(b, 8, r);
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        tick(8);
    endtask

    task automatic cs_end();
        tick(8);
        cs_n = 1'b1;
        tick(8);
    endtask

    initial begin
        logic [7:0] r, r0, r1, acc;
        int         wb, rb;

        rst  = 1'b1;
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        tick(3);
        check("rst_miso", miso, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_mem_re", mem_re, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_bad_cmd", bad_cmd, 0);
        rst = 1'b0;
        tick(4);

        // write burst 02 00 12 34 AA 55
        wb = we_cnt;
        cs_begin();
        check("wr_busy", busy, 1);
        check("wr_oe", miso_oe, 1);
        spi_byte(8'h02, r);
        spi_byte(8'h00, r);
        spi_byte(8'h12, r);
        spi_byte(8'h34, r);
        spi_byte(8'hAA, r);
        spi_byte(8'h55, r);
        cs_end();
        check("wr_count", we_cnt - wb, 2);
        check("wr0_addr", we_addr[wb], 16'h1234);
        check("wr0_data", we_data[wb], 8'hAA);
        check("wr1_addr", we_addr[wb+1], 16'h1235);
        check("wr1_data", we_data[wb+1], 8'h55);
        check("wr_bad_cmd", bad_cmd, 0);
        check("wr_idle", busy, 0);

        // read burst 03 00 12 34 + 16 bits
        rb = re_cnt;
        cs_begin();
        spi_byte(8'h03, r);
        spi_byte(8'h00, r);
        spi_byte(8'h12, r);
        spi_byte(8'h34, r);
        spi_byte(8'h00, r0);
        spi_byte(8'h00, r1);
        check("rd_oe", miso_oe, 1);
        cs_end();
        check("rd_byte0", r0, 8'hAA);
        check("rd_byte1", r1, 8'h55);
        check("rd_re0_addr", re_addr[rb], 16'h1234);
        check("rd_re1_addr", re_addr[rb+1], 16'h1235);
        check("rd_oe_off", miso_oe, 0);

        // address wrap 02 00 FF FF 11 22
        wb = we_cnt;
        cs_begin();
        spi_byte(8'h02, r);
        spi_byte(8'h00, r);
        spi_byte(8'hFF, r);
        spi_byte(8'hFF, r);
        spi_byte(8'h11, r);
        spi_byte(8'h22, r);
        cs_end();
        check("wrap_count", we_cnt - wb, 2);
        check("wrap0_addr", we_addr[wb], 16'hFFFF);
        check("wrap0_data", we_data[wb], 8'h11);
        check("wrap1_addr", we_addr[wb+1], 16'h0000);
        check("wrap1_data", we_data[wb+1], 8'h22);

        // unsupported opcode then a valid read
        wb  = we_cnt;
        rb  = re_cnt;
        acc = '0;
        cs_begin();
        spi_byte(8'h9F, r);
        acc |= r;
        for (int k = 0; k < 4; k++) begin
            spi_byte(8'hFF, r);
            acc |= r;
        end
        check("bad_busy", busy, 1);
        cs_end();
        check("bad_miso", acc, 0);
        check("bad_no_we", we_cnt - wb, 0);
        check("bad_no_re", re_cnt - rb, 0);
        check("bad_flag", bad_cmd, 1);
        cs_begin();
        spi_byte(8'h03, r);
        spi_byte(8'h00, r);
        spi_byte(8'h12, r);
        spi_byte(8'h35, r);
        spi_byte(8'h00, r0);
        cs_end();
        check("bad_then_rd", r0, 8'h55);
        check("bad_sticky", bad_cmd, 1);

        // abort after 5 bits of the second write byte
        wb = we_cnt;
        cs_begin();
        spi_byte(8'h02, r);
        spi_byte(8'h00, r);
        spi_byte(8'h20, r);
        spi_byte(8'h00, r);
        spi_byte(8'h33, r);
        spi_bits(8'h44, 5, r);
        cs_n = 1'b1;
        tick(3);
        check("abort_busy", busy, 0);
        check("abort_oe", miso_oe, 0);
        tick(8);
        check("abort_we_count", we_cnt - wb, 1);
        check("abort_addr", we_addr[wb], 16'h2000);
        check("abort_data", we_data[wb], 8'h33);

        // reset during RD_DATA
        cs_begin();
        spi_byte(8'h03, r);
        spi_byte(8'h00, r);
        spi_byte(8'h12, r);
        spi_byte(8'h34, r);
        tick(8);
        check("mid_rd_bit7", miso, 1);
        rst = 1'b1;
        tick(1);
        check("mrst_miso", miso, 0);
        check("mrst_oe", miso_oe, 0);
        check("mrst_re", mem_re, 0);
        check("mrst_we", mem_we, 0);
        check("mrst_addr", mem_addr, 0);
        check("mrst_wdata", mem_wdata, 0);
        check("mrst_busy", busy, 0);
        check("mrst_bad_cmd", bad_cmd, 0);
        rst  = 1'b0;
        cs_n = 1'b1;
        tick(10);
        check("post_idle", busy, 0);
        check("strobe_rules", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
